// File: rtl/psm_pkg.sv
// psm_pkg: shared state type, default widths and scramble helper for psm_sram_bridge
package psm_pkg;
    typedef enum logic [2:0] {IDLE, WR, RD0, RD1, ACK, ZERO} state_t;
    localparam int DEF_NUM_BANKS = 2;
    localparam int DEF_ADDR_W = 9;
    localparam int DEF_DATA_W = 32;
    function automatic int bank_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
    // Byte-lane scramble so any DATA_W that is a multiple of 8 reuses it per lane
    function automatic logic [7:0] scramble(input logic [7:0] data, input logic [7:0] key);
        return data ^ key;
    endfunction
endpackage

// File: rtl/psm_key_reg.sv
// psm_key_reg: scramble key register with pending rekey and zeroize requests
module psm_key_reg import psm_pkg::*; #(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] key,
    input  logic              key_valid,
    input  logic              rekey,
    input  logic              zeroize,
    input  logic              idle,
    input  logic              sweep,
    output logic [DATA_W-1:0] key_q,
    output logic              zero_req
);
    logic rekey_pend, zero_pend;
    assign zero_req = zero_pend | zeroize;
    // The key only moves while the FSM is idle, so a transaction never sees two keys
    always_ff @(posedge clk)
        if (rst) begin
            key_q <= '0;
            rekey_pend <= 1'b0;
            zero_pend <= 1'b0;
        end else begin
            if (idle && rekey_pend) key_q <= key;
            rekey_pend <= (rekey && key_valid) || (rekey_pend && !idle);
            zero_pend <= zero_req && !idle && !sweep;
        end
endmodule

// File: rtl/psm_sram_bridge.sv
// psm_sram_bridge: Wishbone slave to scrambled multi-bank 1RW1R SRAM with rekey and zeroize
module psm_sram_bridge import psm_pkg::*; #(
    parameter int NUM_BANKS = DEF_NUM_BANKS,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic                          wb_clk_i,
    input  logic                          wb_rst_i,
    input  logic                          wbs_cyc_i,
    input  logic                          wbs_stb_i,
    input  logic                          wbs_we_i,
    input  logic [DATA_W/8-1:0]           wbs_sel_i,
    input  logic [31:0]                   wbs_adr_i,
    input  logic [DATA_W-1:0]             wbs_dat_i,
    output logic                          wbs_ack_o,
    output logic [DATA_W-1:0]             wbs_dat_o,
    input  logic [DATA_W-1:0]             key_i,
    input  logic                          key_valid_i,
    input  logic                          rekey_i,
    input  logic                          zeroize_i,
    output logic                          busy_o,
    output logic [NUM_BANKS-1:0]          sram_csb0_o,
    output logic [NUM_BANKS-1:0]          sram_web0_o,
    output logic [NUM_BANKS*DATA_W/8-1:0] sram_wmask0_o,
    output logic [ADDR_W-1:0]             sram_addr0_o,
    output logic [ADDR_W-1:0]             sram_addr1_o,
    output logic [DATA_W-1:0]             sram_din0_o,
    output logic [NUM_BANKS-1:0]          sram_csb1_o,
    input  logic [NUM_BANKS*DATA_W-1:0]   sram_dout1_i
);
    localparam int BANK_W = bank_w(NUM_BANKS);
    localparam int SW = DATA_W / 8;
    localparam int CNT_W = BANK_W + ADDR_W;
    localparam logic [CNT_W-1:0] LAST = {BANK_W'(NUM_BANKS - 1), {ADDR_W{1'b1}}};

    state_t state;
    logic [BANK_W-1:0] bank_q, req_bank;
    logic [ADDR_W-1:0] req_word;
    logic [CNT_W-1:0] cnt, z_idx;
    logic [DATA_W-1:0] key_q, din_scr, dout_sel, dout_clr;
    logic [NUM_BANKS-1:0] req_hot, z_hot;
    logic [NUM_BANKS*SW-1:0] req_mask;
    logic req_ok, zero_req, sweep_step, unused_adr;

    assign req_word = wbs_adr_i[ADDR_W+1:2];
    assign req_bank = wbs_adr_i[ADDR_W+2 +: BANK_W];
    assign req_ok = {1'b0, req_bank} < (BANK_W+1)'(NUM_BANKS);
    assign req_hot = req_ok ? NUM_BANKS'(1) << req_bank : '0;
    assign unused_adr = ^{wbs_adr_i[31:ADDR_W+2+BANK_W], wbs_adr_i[1:0]};
    assign dout_sel = sram_dout1_i[bank_q*DATA_W +: DATA_W];
    // Sweep index presented on the SRAM port next cycle: 0 on entry, then cnt+1
    assign z_idx = (state == ZERO) ? cnt + CNT_W'(1) : '0;
    assign z_hot = NUM_BANKS'(1) << z_idx[ADDR_W +: BANK_W];
    assign sweep_step = (state == IDLE && zero_req) || (state == ZERO && cnt != LAST);

    for (genvar i = 0; i < SW; i++) begin : g_lane
        assign din_scr[i*8 +: 8] = scramble(wbs_dat_i[i*8 +: 8], key_q[i*8 +: 8]);
        assign dout_clr[i*8 +: 8] = scramble(dout_sel[i*8 +: 8], key_q[i*8 +: 8]);
    end
    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_mask
        assign req_mask[b*SW +: SW] = req_hot[b] ? wbs_sel_i : '0;
    end

    psm_key_reg #(.DATA_W(DATA_W)) u_key (
        .clk(wb_clk_i), .rst(wb_rst_i), .key(key_i), .key_valid(key_valid_i),
        .rekey(rekey_i), .zeroize(zeroize_i), .idle(state == IDLE), .sweep(state == ZERO),
        .key_q(key_q), .zero_req(zero_req)
    );

    always_ff @(posedge wb_clk_i)
        if (wb_rst_i) begin
            state <= IDLE;
            bank_q <= '0;
            cnt <= '0;
            sram_csb0_o <= '1;
            sram_web0_o <= '1;
            sram_csb1_o <= '1;
            sram_wmask0_o <= '0;
            sram_addr0_o <= '0;
            sram_addr1_o <= '0;
            sram_din0_o <= '0;
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
            busy_o <= 1'b0;
        end else if (sweep_step) begin
            state <= ZERO;
            busy_o <= 1'b1;
            cnt <= z_idx;
            sram_csb0_o <= ~z_hot;
            sram_web0_o <= ~z_hot;
            sram_wmask0_o <= '1;
            sram_addr0_o <= z_idx[ADDR_W-1:0];
            sram_din0_o <= '0;
        end else
            case (state)
                IDLE: if (wbs_cyc_i && wbs_stb_i) begin
                    bank_q <= req_bank;
                    if (!req_ok) begin
                        state <= ACK;
                        wbs_ack_o <= 1'b1;
                        if (!wbs_we_i) wbs_dat_o <= '0;
                    end else if (wbs_we_i) begin
                        state <= WR;
                        sram_csb0_o <= ~req_hot;
                        sram_web0_o <= ~req_hot;
                        sram_wmask0_o <= req_mask;
                        sram_addr0_o <= req_word;
                        sram_din0_o <= din_scr;
                    end else begin
                        state <= RD0;
                        sram_csb1_o <= ~req_hot;
                        sram_addr1_o <= req_word;
                    end
                end
                WR: begin
                    state <= ACK;
                    sram_csb0_o <= '1;
                    sram_web0_o <= '1;
                    sram_wmask0_o <= '0;
                    wbs_ack_o <= 1'b1;
                end
                RD0: begin
                    state <= RD1;
                    sram_csb1_o <= '1;
                end
                RD1: begin
                    state <= ACK;
                    wbs_dat_o <= dout_clr;
                    wbs_ack_o <= 1'b1;
                end
                ACK: begin
                    state <= IDLE;
                    wbs_ack_o <= 1'b0;
                end
                ZERO: begin
                    state <= IDLE;
                    busy_o <= 1'b0;
                    sram_csb0_o <= '1;
                    sram_web0_o <= '1;
                    sram_wmask0_o <= '0;
                end
                default: state <= IDLE;
            endcase
endmodule

// File: tb/tb_psm_sram_bridge.sv
// tb_psm_sram_bridge: vector table, corner sequences and randomized traffic against a reference model
module tb_psm_sram_bridge;
    localparam int NB = 2, AW = 9, DW = 32, SW = DW / 8, WORDS = 1 << AW;

    typedef struct {
        logic        rk;
        logic [31:0] key;
        logic        we;
        logic [31:0] adr;
        logic [3:0]  sel;
        logic [31:0] dat;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    logic clk = 1'b0, rst = 1'b1;
    always #5 clk = ~clk;

    logic cyc = 0, stb = 0, we = 0, cyc3 = 0;
    logic [SW-1:0] sel = '0;
    logic [31:0] adr = '0;
    logic [DW-1:0] dat = '0, key = '0;
    logic key_valid = 0, rekey = 0, zeroize = 0;
    logic ack, busy, ack3, busy3;
    logic [DW-1:0] dat_o, din0, dat3, din3;
    logic [NB-1:0] csb0, web0, csb1;
    logic [NB*SW-1:0] wmask0;
    logic [AW-1:0] addr0, addr1, a0_3, a1_3;
    logic [NB*DW-1:0] dout1;
    logic [2:0] csb0_3, web0_3, csb1_3;
    logic [3*SW-1:0] wmask3;

    psm_sram_bridge #(.NUM_BANKS(NB), .ADDR_W(AW), .DATA_W(DW)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we),
        .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(dat), .wbs_ack_o(ack), .wbs_dat_o(dat_o),
        .key_i(key), .key_valid_i(key_valid), .rekey_i(rekey), .zeroize_i(zeroize), .busy_o(busy),
        .sram_csb0_o(csb0), .sram_web0_o(web0), .sram_wmask0_o(wmask0), .sram_addr0_o(addr0),
        .sram_addr1_o(addr1), .sram_din0_o(din0), .sram_csb1_o(csb1), .sram_dout1_i(dout1)
    );

    psm_sram_bridge #(.NUM_BANKS(3), .ADDR_W(AW), .DATA_W(DW)) dut3 (
        .wb_clk_i(clk), .wb_rst_i(rst), .wbs_cyc_i(cyc3), .wbs_stb_i(cyc3), .wbs_we_i(we),
        .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(dat), .wbs_ack_o(ack3), .wbs_dat_o(dat3),
        .key_i(key), .key_valid_i(1'b0), .rekey_i(1'b0), .zeroize_i(1'b0), .busy_o(busy3),
        .sram_csb0_o(csb0_3), .sram_web0_o(web0_3), .sram_wmask0_o(wmask3), .sram_addr0_o(a0_3),
        .sram_addr1_o(a1_3), .sram_din0_o(din3), .sram_csb1_o(csb1_3), .sram_dout1_i({3*DW{1'b1}})
    );

    // Behavioural 1RW1R macros: port 0 writes with byte mask, port 1 registers read data
    logic [DW-1:0] mem [NB][WORDS];
    always @(posedge clk)
        for (int b = 0; b < NB; b++) begin
            if (!csb0[b] && !web0[b])
                for (int i = 0; i < SW; i++)
                    if (wmask0[b*SW+i]) mem[b][addr0][i*8 +: 8] <= din0[i*8 +: 8];
            if (!csb1[b]) dout1[b*DW +: DW] <= mem[b][addr1];
        end

    logic [DW-1:0] ref_mem [NB][WORDS];
    logic [DW-1:0] ref_key = '0;
    int n_cmp = 0, n_bad = 0;

    function automatic int bank_of(input logic [31:0] a);
        return int'((a / 2048) % NB);
    endfunction
    function automatic int word_of(input logic [31:0] a);
        return int'((a / 4) % WORDS);
    endfunction
    function automatic logic [31:0] backdoor(input logic [31:0] a);
        return mem[bank_of(a)][word_of(a)];
    endfunction
    function automatic logic [31:0] byte_mask(input logic [3:0] s);
        logic [31:0] m;
        for (int i = 0; i < 4; i++) m[i*8 +: 8] = {8{s[i]}};
        return m;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic wb_op(input logic w, input logic [31:0] a, input logic [3:0] s,
                         input logic [31:0] d, output logic [31:0] r, output int lat);
        logic [31:0] m;
        @(negedge clk);
        cyc = 1; stb = 1; we = w; adr = a; sel = s; dat = d;
        lat = -1;
        for (int i = 0; i < 3000 && lat < 0; i++) begin
            @(posedge clk); #1;
            if (ack) lat = i;
        end
        r = dat_o;
        cyc = 0; stb = 0; we = 0;
        @(posedge clk);
        if (w) begin
            m = byte_mask(s);
            ref_mem[bank_of(a)][word_of(a)] = (ref_mem[bank_of(a)][word_of(a)] & ~m) | ((d ^ ref_key) & m);
        end
    endtask

    task automatic do_rekey(input logic [31:0] k, input logic v);
        @(negedge clk);
        key = k; key_valid = v; rekey = 1;
        @(negedge clk);
        rekey = 0; key_valid = 0;
        repeat (2) @(negedge clk);
        if (v) ref_key = k;
    endtask

    task automatic op3(input logic w, input logic [31:0] a, output logic [31:0] r,
                       output int lat, output logic seen);
        @(negedge clk);
        cyc3 = 1; we = w; adr = a; sel = '1; dat = 32'h5555AAAA;
        lat = -1; seen = 0;
        for (int i = 0; i < 20 && lat < 0; i++) begin
            @(posedge clk); #1;
            if (csb0_3 != 3'b111 || csb1_3 != 3'b111 || web0_3 != 3'b111) seen = 1;
            if (ack3) lat = i;
        end
        r = dat3;
        cyc3 = 0; we = 0;
        @(posedge clk);
    endtask

    initial begin
        vec_t tbl [12];
        logic [31:0] r, a, d, e;
        logic [3:0] s;
        logic w, seen, early;
        int lat, bcnt, nz;

        tbl[0]  = '{0, 0, 1, 32'h0000_0814, 4'hF, 32'hDEADBEEF, 32'hDEADBEEF, 1};
        tbl[1]  = '{0, 0, 0, 32'h0000_0814, 4'hF, 32'h0,        32'hDEADBEEF, 2};
        tbl[2]  = '{0, 0, 1, 32'h0000_0020, 4'h3, 32'hFFFFFFFF, 32'h0000FFFF, 1};
        tbl[3]  = '{0, 0, 0, 32'h0000_0020, 4'hF, 32'h0,        32'h0000FFFF, 2};
        tbl[4]  = '{0, 0, 1, 32'h0000_0FFC, 4'hC, 32'hCAFEF00D, 32'hCAFE0000, 1};
        tbl[5]  = '{0, 0, 0, 32'hABC0_0FFC, 4'hF, 32'h0,        32'hCAFE0000, 2};
        tbl[6]  = '{0, 0, 1, 32'h0000_0000, 4'h9, 32'h11223344, 32'h11000044, 1};
        tbl[7]  = '{0, 0, 0, 32'h0000_0000, 4'hF, 32'h0,        32'h11000044, 2};
        tbl[8]  = '{1, 32'hA5A5A5A5, 1, 32'h0000_0814, 4'hF, 32'h12345678, 32'hB791F3DD, 1};
        tbl[9]  = '{0, 0, 0, 32'h0000_0814, 4'hF, 32'h0,        32'h12345678, 2};
        tbl[10] = '{1, 32'h0F0F0F0F, 0, 32'h0000_0814, 4'hF, 32'h0, 32'hB89EFCD2, 2};
        tbl[11] = '{0, 0, 0, 32'h0000_0000, 4'hF, 32'h0,        32'h1E0F0F4B, 2};

        repeat (3) @(posedge clk);
        #1;
        check("rst_ack", {31'b0, ack}, 0);
        check("rst_busy", {31'b0, busy}, 0);
        check("rst_dat", dat_o, 0);
        check("rst_csb", {26'b0, csb0, web0, csb1}, 32'h3F);
        check("rst_wmask_din", {wmask0, din0[23:0]}, 0);
        check("rst_addr", {14'b0, addr0, addr1}, 0);
        @(negedge clk);
        rst = 0;

        // zeroize with a simultaneous read; also initialises the arrays
        @(negedge clk);
        zeroize = 1; cyc = 1; stb = 1; we = 0; adr = 32'h0000_0814; sel = '1;
        @(posedge clk); #1;
        zeroize = 0;
        bcnt = 0; seen = 0; early = 0;
        for (int i = 0; i < 3000 && !seen; i++) begin
            if (busy) bcnt++;
            if (ack) begin seen = 1; early = busy; end
            if (!seen) begin @(posedge clk); #1; end
        end
        r = dat_o;
        cyc = 0; stb = 0;
        @(posedge clk);
        for (int b = 0; b < NB; b++)
            for (int i = 0; i < WORDS; i++) ref_mem[b][i] = '0;
        check("zero_busy_cycles", bcnt, NB * WORDS);
        check("zero_read_acked", {31'b0, seen}, 1);
        check("zero_ack_while_busy", {31'b0, early}, 0);
        check("zero_read_data", r, 0);
        nz = 0;
        for (int b = 0; b < NB; b++)
            for (int i = 0; i < WORDS; i++) if (mem[b][i] !== '0) nz++;
        check("zero_backdoor", nz, 0);

        for (int n = 0; n < 12; n++) begin
            if (tbl[n].rk) do_rekey(tbl[n].key, 1);
            wb_op(tbl[n].we, tbl[n].adr, tbl[n].sel, tbl[n].dat, r, lat);
            check($sformatf("vec%0d_lat", n), lat, tbl[n].lat);
            check($sformatf("vec%0d_%s", n, tbl[n].we ? "backdoor" : "read"),
                  tbl[n].we ? backdoor(tbl[n].adr) : r, tbl[n].exp);
        end

        do_rekey(32'hFFFFFFFF, 0);
        wb_op(0, 32'h0000_0814, 4'hF, 0, r, lat);
        check("rekey_no_valid", r, 32'hB89EFCD2);

        // reset while the read sits in RD1
        @(negedge clk);
        cyc = 1; stb = 1; we = 0; adr = 32'h0000_0814;
        @(posedge clk); #1;
        check("rd0_csb1", {30'b0, csb1}, 32'h1);
        @(posedge clk); #1;
        rst = 1;
        @(posedge clk); #1;
        check("rst_rd1_ack", {31'b0, ack}, 0);
        check("rst_rd1_csb", {28'b0, csb0, csb1}, 32'hF);
        @(negedge clk);
        rst = 0; cyc = 0; stb = 0;
        ref_key = '0;
        wb_op(0, 32'h0000_0814, 4'hF, 0, r, lat);
        check("post_rst_read", r, 32'hB791F3DD);
        check("post_rst_lat", lat, 2);

        op3(0, 32'h0000_1814, r, lat, seen);
        check("oob_rd_lat", lat, 0);
        check("oob_rd_data", r, 0);
        check("oob_rd_nosel", {31'b0, seen}, 0);
        op3(1, 32'h0000_1FFC, r, lat, seen);
        check("oob_wr_lat", lat, 0);
        check("oob_wr_nosel", {31'b0, seen}, 0);
        op3(0, 32'h0000_1008, r, lat, seen);
        check("bank2_rd_data", r, 32'hFFFFFFFF);
        check("bank2_rd_lat", lat, 2);
        check("bank2_rd_sel", {31'b0, seen}, 1);

        for (int n = 0; n < 300; n++) begin
            if (n % 25 == 0) do_rekey($urandom, 1'($urandom_range(0, 1)));
            w = 1'($urandom_range(0, 1));
            a = ($urandom & 32'hFFFF_E000) | (32'($urandom_range(0, NB - 1)) << 11)
                | (32'((n % 9 == 0) ? WORDS - 1 : $urandom_range(0, 15)) << 2);
            s = 4'($urandom_range(0, 15));
            d = $urandom;
            e = ref_mem[bank_of(a)][word_of(a)] ^ ref_key;
            wb_op(w, a, s, d, r, lat);
            if (w) begin
                check("rand_wr_lat", lat, 1);
                check("rand_wr_backdoor", backdoor(a), ref_mem[bank_of(a)][word_of(a)]);
            end else begin
                check("rand_rd_lat", lat, 2);
                check("rand_rd_data", r, e);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
